// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the GPIO bank: register map and counter sizing.
package gpio_bank_pkg;

   localparam int GPIO_AW = 3;
   localparam int DB_CW   = 4;

   typedef enum logic [GPIO_AW-1:0] {
      GPIO_OUT     = 3'd0,
      GPIO_DIR     = 3'd1,
      GPIO_IN      = 3'd2,
      GPIO_RISE_EN = 3'd3,
      GPIO_FALL_EN = 3'd4,
      GPIO_STATUS  = 3'd5
   } gpio_reg_e;

   // Counter width for a modulus of n, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO channel: two-flop synchroniser, tick-paced debounce counter,
// debounced level and single-cycle rise/fall pulses aligned with the
// cycle in which the debounced level is seen to change.
module gpio_debounce
   import gpio_bank_pkg::*;
#(
   parameter int DB_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   input  logic tick_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [DB_CW-1:0] DB_TC = DB_CW'(DB_LEN - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             rise_q;
   logic             fall_q;
   logic [DB_CW-1:0] cnt_q;

   // Synchronise the pad, then accept a new level after DB_LEN consecutive
   // differing ticks; any agreeing tick restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         if (tick_i) begin
            if (sync2_q != level_q) begin
               if (cnt_q == DB_TC) begin
                  level_q <= sync2_q;
                  cnt_q   <= '0;
                  rise_q  <= sync2_q;
                  fall_q  <= ~sync2_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end else begin
               cnt_q <= '0;
            end
         end
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: register file on a simple valid/we bus, pad output drive,
// per-pin debounced inputs and edge-triggered sticky status with a
// registered level interrupt.
module gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter int N_PINS   = 36,
   parameter int TICK_DIV = 50000,
   parameter int DB_LEN   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               bus_valid,
   input  logic               bus_we,
   input  logic [GPIO_AW-1:0] bus_addr,
   input  logic [N_PINS-1:0]  bus_wdata,
   output logic [N_PINS-1:0]  bus_rdata,
   output logic               bus_rvalid,
   input  logic [N_PINS-1:0]  pin_i,
   output logic [N_PINS-1:0]  pin_o,
   output logic [N_PINS-1:0]  pin_oe,
   output logic               irq
);

   localparam int            TW      = cnt_width(TICK_DIV);
   localparam logic [TW-1:0] TICK_TC = TW'(TICK_DIV - 1);

   logic [TW-1:0]     tick_cnt_q;
   logic              tick;

   logic [N_PINS-1:0] out_q;
   logic [N_PINS-1:0] dir_q;
   logic [N_PINS-1:0] rise_en_q;
   logic [N_PINS-1:0] fall_en_q;
   logic [N_PINS-1:0] status_q;
   logic [N_PINS-1:0] status_d;
   logic [N_PINS-1:0] rdata_q;
   logic [N_PINS-1:0] rdata_d;
   logic              rvalid_q;
   logic              irq_q;

   logic [N_PINS-1:0] level;
   logic [N_PINS-1:0] rise;
   logic [N_PINS-1:0] fall;

   logic              wr_en;
   logic              rd_en;
   gpio_reg_e         reg_sel;

   assign wr_en   = bus_valid & bus_we;
   assign rd_en   = bus_valid & ~bus_we;
   assign reg_sel = gpio_reg_e'(bus_addr);

   // Free-running sample-tick divider; tick is high in the wrap cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
      end else if (tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + 1'b1;
      end
   end

   assign tick = (tick_cnt_q == TICK_TC);

   genvar gi;
   generate
      for (gi = 0; gi < N_PINS; gi++) begin : g_pin
         gpio_debounce #(
            .DB_LEN (DB_LEN)
         ) u_db (
            .clk     (clk),
            .rst     (rst),
            .pin_i   (pin_i[gi]),
            .tick_i  (tick),
            .level_o (level[gi]),
            .rise_o  (rise[gi]),
            .fall_o  (fall[gi])
         );
      end
   endgenerate

   // Sticky status: new enabled edges are OR-ed in after the W1C mask so a
   // coincident clear never loses an edge.
   always_comb begin
      logic [N_PINS-1:0] clr;
      clr = '0;
      if (wr_en && (reg_sel == GPIO_STATUS)) begin
         clr = bus_wdata;
      end
      status_d = (status_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
   end

   // Read data mux; unmapped addresses read as zero.
   always_comb begin
      rdata_d = '0;
      case (reg_sel)
         GPIO_OUT:     rdata_d = out_q;
         GPIO_DIR:     rdata_d = dir_q;
         GPIO_IN:      rdata_d = level;
         GPIO_RISE_EN: rdata_d = rise_en_q;
         GPIO_FALL_EN: rdata_d = fall_en_q;
         GPIO_STATUS:  rdata_d = status_q;
         default:      rdata_d = '0;
      endcase
   end

   // Writable registers; writes to IN and unmapped addresses fall through.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q     <= '0;
         dir_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
      end else if (wr_en) begin
         case (reg_sel)
            GPIO_OUT:     out_q     <= bus_wdata;
            GPIO_DIR:     dir_q     <= bus_wdata;
            GPIO_RISE_EN: rise_en_q <= bus_wdata;
            GPIO_FALL_EN: fall_en_q <= bus_wdata;
            default:      ;
         endcase
      end
   end

   // Status and interrupt; irq follows status by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         status_q <= status_d;
         irq_q    <= |status_q;
      end
   end

   // Read response: strobe for one cycle after a read, data held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rd_en;
         if (rd_en) begin
            rdata_q <= rdata_d;
         end
      end
   end

   assign pin_o      = out_q;
   assign pin_oe     = dir_q;
   assign bus_rdata  = rdata_q;
   assign bus_rvalid = rvalid_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank with N_PINS=8, TICK_DIV=1, DB_LEN=3.
// Reads push their expected data into a queue; a monitor pops on bus_rvalid.
module tb_gpio_bank;

   localparam int NP = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          bus_valid;
   logic          bus_we;
   logic [2:0]    bus_addr;
   logic [NP-1:0] bus_wdata;
   logic [NP-1:0] bus_rdata;
   logic          bus_rvalid;
   logic [NP-1:0] pin_i;
   logic [NP-1:0] pin_o;
   logic [NP-1:0] pin_oe;
   logic          irq;

   int total = 0;
   int bad   = 0;

   logic [NP-1:0] exp_q[$];
   logic          rd_pend = 1'b0;

   gpio_bank #(
      .N_PINS   (NP),
      .TICK_DIV (1),
      .DB_LEN   (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus_valid  (bus_valid),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_rvalid (bus_rvalid),
      .pin_i      (pin_i),
      .pin_o      (pin_o),
      .pin_oe     (pin_oe),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Track which cycles must carry a read strobe.
   always @(posedge clk) rd_pend <= bus_valid && !bus_we && !rst;

   // Monitor: strobe timing and scoreboard comparison of read data.
   always @(negedge clk) begin
      if (bus_rvalid || rd_pend) begin
         total++;
         if (bus_rvalid !== rd_pend) begin
            bad++;
            $display("FAIL rvalid_strobe: got %b want %b at %0t", bus_rvalid, rd_pend, $time);
         end
      end
      if (bus_rvalid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rdata_unexpected: got %h with empty scoreboard at %0t", bus_rdata, $time);
         end else begin
            logic [NP-1:0] e;
            e = exp_q.pop_front();
            if (bus_rdata !== e) begin
               bad++;
               $display("FAIL rdata: got %h want %h at %0t", bus_rdata, e, $time);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // All bus tasks start and end on a falling edge and occupy one cycle.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [NP-1:0] d);
      bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      @(negedge clk);
      bus_valid = 1'b0; bus_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [NP-1:0] e);
      bus_valid = 1'b1; bus_we = 1'b0; bus_addr = a;
      exp_q.push_back(e);
      @(negedge clk);
      bus_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0;
      bus_wdata = '0; pin_i = '0;
      idle(3);
      chk("reset_pin_o", 64'(pin_o), 64'h0);
      chk("reset_pin_oe", 64'(pin_oe), 64'h0);
      chk("reset_irq", 64'(irq), 64'h0);
      chk("reset_rvalid", 64'(bus_rvalid), 64'h0);
      chk("reset_rdata", 64'(bus_rdata), 64'h0);
      rst = 1'b0;
      idle(1);
      rd(3'd5, 8'h00);

      // Output register and direction drive the pads.
      wr(3'd0, 8'hA5);
      wr(3'd1, 8'h0F);
      chk("pin_o", 64'(pin_o), 64'hA5);
      chk("pin_oe", 64'(pin_oe), 64'h0F);
      rd(3'd1, 8'h0F);
      rd(3'd0, 8'hA5);

      // Rising edge on pin 2: level after 2 sync + 3 tick edges.
      wr(3'd3, 8'h04);
      idle(2);
      pin_i[2] = 1'b1;
      idle(4);
      rd(3'd2, 8'h00);
      rd(3'd2, 8'h04);
      chk("irq_before", 64'(irq), 64'h0);
      rd(3'd5, 8'h04);
      chk("irq_after", 64'(irq), 64'h1);

      // Two-cycle glitch on pin 5 must be rejected.
      pin_i[5] = 1'b1;
      idle(2);
      pin_i[5] = 1'b0;
      idle(6);
      rd(3'd2, 8'h04);
      rd(3'd5, 8'h04);

      // W1C coincident with a new rise on pin 2: set wins.
      pin_i[2] = 1'b0;
      idle(10);
      rd(3'd2, 8'h00);
      pin_i[2] = 1'b1;
      idle(5);
      wr(3'd5, 8'h04);
      rd(3'd5, 8'h04);
      wr(3'd5, 8'h04);
      chk("irq_hold", 64'(irq), 64'h1);
      idle(1);
      chk("irq_drop", 64'(irq), 64'h0);
      rd(3'd5, 8'h00);

      // Unmapped reads and ignored write to IN.
      rd(3'd7, 8'h00);
      rd(3'd6, 8'h00);
      wr(3'd2, 8'hFF);
      rd(3'd2, 8'h04);
      chk("pin_o_kept", 64'(pin_o), 64'hA5);

      // Falling-edge detection on pin 0.
      pin_i[0] = 1'b1;
      idle(8);
      rd(3'd5, 8'h00);
      wr(3'd4, 8'h01);
      pin_i[0] = 1'b0;
      idle(8);
      rd(3'd5, 8'h01);
      chk("irq_fall", 64'(irq), 64'h1);
      rd(3'd4, 8'h01);
      rd(3'd3, 8'h04);
      wr(3'd5, 8'hFF);
      idle(2);
      chk("irq_clear", 64'(irq), 64'h0);

      // Reset mid-debounce with a read issued in the reset cycle.
      wr(3'd3, 8'h0C);
      pin_i[3] = 1'b1;
      idle(3);
      rst = 1'b1;
      bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 3'd1;
      idle(1);
      bus_valid = 1'b0;
      idle(1);
      chk("rst_pin_o", 64'(pin_o), 64'h0);
      chk("rst_pin_oe", 64'(pin_oe), 64'h0);
      chk("rst_irq", 64'(irq), 64'h0);
      chk("rst_rvalid", 64'(bus_rvalid), 64'h0);
      chk("rst_rdata", 64'(bus_rdata), 64'h0);
      rst = 1'b0;
      // Pins 2 and 3 high at release: only pin 2 is armed afterwards.
      wr(3'd3, 8'h04);
      idle(10);
      rd(3'd2, 8'h0C);
      rd(3'd5, 8'h04);
      chk("irq_post_rst", 64'(irq), 64'h1);
      rd(3'd1, 8'h00);

      idle(3);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
